dma_channel_arbiter: RTL and testbench

- Upstream stage of the DMA controller engine.
- Collects per-channel peripheral requests, masks them with CSR channel enables and per-channel busy state, and selects one channel: highest priority first, round-robin among equal priorities.
- Offers the selected channel to the engine over a valid/ready handshake.
- Keeps each channel busy until the engine reports its transaction finished.

---
 rtl/dma_pkg.sv | 16 +
 rtl/dma_rr_prio_select.sv | 52 +++++
 rtl/dma_channel_arbiter.sv | 113 +++++++++++
 tb/tb_dma_channel_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types for the DMA controller: channel index, priority and arbiter state.
package dma_pkg;

  localparam int DMA_CHANNELS = 4;
  localparam int DMA_PRIO_W   = 2;
  localparam int DMA_CH_W     = (DMA_CHANNELS > 1) ? $clog2(DMA_CHANNELS) : 1;

  typedef logic [DMA_CH_W-1:0]   chan_idx_t;
  typedef logic [DMA_PRIO_W-1:0] prio_t;

  typedef enum logic {
    ARB_IDLE_S,
    ARB_OFFER_S
  } arb_state_t;

endpackage

// File: rtl/dma_rr_prio_select.sv
// Combinational selector: highest priority wins, ties broken round-robin
// starting at rr_ptr_i and wrapping upward. Also reused by bus-side arbitration.
module dma_rr_prio_select
  import dma_pkg::*;
#(
  parameter int CHANNELS_AMOUNT = DMA_CHANNELS,
  parameter int PRIO_W          = DMA_PRIO_W,
  localparam int CH_W           = (CHANNELS_AMOUNT > 1) ? $clog2(CHANNELS_AMOUNT) : 1
) (
  input  logic [CHANNELS_AMOUNT-1:0]        eligible_i,
  input  logic [CHANNELS_AMOUNT*PRIO_W-1:0] priority_i,
  input  logic [CH_W-1:0]                   rr_ptr_i,
  output logic                              found_o,
  output logic [CH_W-1:0]                   channel_o,
  output logic [PRIO_W-1:0]                 priority_o
);

  logic [PRIO_W-1:0] prio_arr [CHANNELS_AMOUNT];
  logic [PRIO_W-1:0] max_prio;
  logic              hit;
  int                idx;

  for (genvar gi = 0; gi < CHANNELS_AMOUNT; gi++) begin : g_unpack
    assign prio_arr[gi] = priority_i[gi*PRIO_W +: PRIO_W];
  end

  always_comb begin
    max_prio = '0;
    for (int i = 0; i < CHANNELS_AMOUNT; i++) begin
      if (eligible_i[i] && (prio_arr[i] > max_prio)) max_prio = prio_arr[i];
    end
  end

  // Scan one full lap from rr_ptr_i; the first eligible channel at max priority wins.
  always_comb begin
    hit       = 1'b0;
    channel_o = '0;
    idx       = 0;
    for (int k = 0; k < CHANNELS_AMOUNT; k++) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= CHANNELS_AMOUNT) idx = idx - CHANNELS_AMOUNT;
      if (!hit && eligible_i[idx] && (prio_arr[idx] == max_prio)) begin
        hit       = 1'b1;
        channel_o = CH_W'(idx);
      end
    end
  end

  assign found_o    = |eligible_i;
  assign priority_o = max_prio;

endmodule

// File: rtl/dma_channel_arbiter.sv
// Upstream DMA stage: picks a requesting channel, offers it to the engine over
// valid/ready, and keeps it busy until the engine reports the transaction done.
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter int CHANNELS_AMOUNT = DMA_CHANNELS,
  parameter int PRIO_W          = DMA_PRIO_W,
  localparam int CH_W           = (CHANNELS_AMOUNT > 1) ? $clog2(CHANNELS_AMOUNT) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [CHANNELS_AMOUNT-1:0]        request_i,
  input  logic [CHANNELS_AMOUNT-1:0]        ch_enable_i,
  input  logic [CHANNELS_AMOUNT*PRIO_W-1:0] ch_priority_i,
  output logic                              arb_valid_o,
  output logic [CH_W-1:0]                   arb_channel_o,
  output logic [PRIO_W-1:0]                 arb_priority_o,
  input  logic                              arb_ready_i,
  input  logic                              done_valid_i,
  input  logic [CH_W-1:0]                   done_channel_i,
  output logic [CHANNELS_AMOUNT-1:0]        busy_o,
  output logic                              done_err_o
);

  localparam logic [31:0]     CH_COUNT = 32'(CHANNELS_AMOUNT);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS_AMOUNT - 1);

  arb_state_t                 state_q, state_d;
  logic [CH_W-1:0]            chan_q, chan_d;
  logic [CH_W-1:0]            rr_q, rr_d;
  logic [PRIO_W-1:0]          prio_q, prio_d;
  logic [CHANNELS_AMOUNT-1:0] busy_q, busy_d;
  logic                       err_q, err_d;

  logic [CHANNELS_AMOUNT-1:0] eligible;
  logic                       sel_found;
  logic [CH_W-1:0]            sel_chan;
  logic [PRIO_W-1:0]          sel_prio;
  logic                       done_in_range;

  assign eligible      = request_i & ch_enable_i & ~busy_q;
  assign done_in_range = (32'(done_channel_i) < CH_COUNT);

  dma_rr_prio_select #(
    .CHANNELS_AMOUNT(CHANNELS_AMOUNT),
    .PRIO_W         (PRIO_W)
  ) u_select (
    .eligible_i(eligible),
    .priority_i(ch_priority_i),
    .rr_ptr_i  (rr_q),
    .found_o   (sel_found),
    .channel_o (sel_chan),
    .priority_o(sel_prio)
  );

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    prio_d  = prio_q;
    rr_d    = rr_q;
    busy_d  = busy_q;
    err_d   = 1'b0;

    // Done is handled first so an accept in the same cycle can still set its own bit.
    if (done_valid_i) begin
      if (done_in_range && busy_q[done_channel_i]) busy_d[done_channel_i] = 1'b0;
      else                                         err_d = 1'b1;
    end

    case (state_q)
      ARB_IDLE_S: begin
        if (sel_found) begin
          chan_d  = sel_chan;
          prio_d  = sel_prio;
          state_d = ARB_OFFER_S;
        end
      end
      ARB_OFFER_S: begin
        if (arb_ready_i) begin
          busy_d[chan_q] = 1'b1;
          rr_d           = (chan_q == LAST_CH) ? '0 : chan_q + CH_W'(1);
          state_d        = ARB_IDLE_S;
        end
      end
      default: state_d = ARB_IDLE_S;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE_S;
      chan_q  <= '0;
      prio_q  <= '0;
      rr_q    <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      prio_q  <= prio_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign arb_valid_o    = (state_q == ARB_OFFER_S);
  assign arb_channel_o  = chan_q;
  assign arb_priority_o = prio_q;
  assign busy_o         = busy_q;
  assign done_err_o     = err_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter: directed scenarios plus a
// randomized run against a priority/round-robin reference model.
module tb_dma_channel_arbiter;

  localparam int N  = 4;
  localparam int PW = 2;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] request_i = '0;
  logic [N-1:0] ch_enable_i = '0;
  logic [N*PW-1:0] ch_priority_i = '0;
  logic         arb_valid_o;
  logic [1:0]   arb_channel_o;
  logic [PW-1:0] arb_priority_o;
  logic         arb_ready_i = 1'b0;
  logic         done_valid_i = 1'b0;
  logic [1:0]   done_channel_i = '0;
  logic [N-1:0] busy_o;
  logic         done_err_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [N-1:0] m_busy;
  int           m_rr;
  bit           m_offer;
  int           m_ch;
  int           m_prio;
  bit           m_err;

  dma_channel_arbiter #(.CHANNELS_AMOUNT(N), .PRIO_W(PW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .request_i     (request_i),
    .ch_enable_i   (ch_enable_i),
    .ch_priority_i (ch_priority_i),
    .arb_valid_o   (arb_valid_o),
    .arb_channel_o (arb_channel_o),
    .arb_priority_o(arb_priority_o),
    .arb_ready_i   (arb_ready_i),
    .done_valid_i  (done_valid_i),
    .done_channel_i(done_channel_i),
    .busy_o        (busy_o),
    .done_err_o    (done_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    request_i = '0; ch_enable_i = '0; ch_priority_i = '0;
    arb_ready_i = 1'b0; done_valid_i = 1'b0; done_channel_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic m_reset();
    m_busy = '0; m_rr = 0; m_offer = 0; m_ch = 0; m_prio = 0; m_err = 0;
  endtask

  // Highest priority level first; within a level, walk channels from rr upward.
  function automatic void m_pick(input logic [N-1:0] elig, input logic [N*PW-1:0] prios,
                                 input int rr, output bit found, output int ch, output int pr);
    int c;
    found = 0; ch = 0; pr = 0;
    for (int p = (1 << PW) - 1; p >= 0; p--) begin
      for (int k = 0; k < N; k++) begin
        c = (rr + k) % N;
        if (!found && elig[c] && (int'(prios[c*PW +: PW]) == p)) begin
          found = 1; ch = c; pr = p;
        end
      end
    end
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic m_step();
    logic [N-1:0] nb;
    bit f;
    int c, p;
    nb = m_busy;
    m_err = 0;
    if (done_valid_i) begin
      if (int'(done_channel_i) < N && m_busy[done_channel_i]) nb[done_channel_i] = 1'b0;
      else m_err = 1;
    end
    if (m_offer) begin
      if (arb_ready_i) begin
        nb[m_ch] = 1'b1;
        m_rr = (m_ch + 1) % N;
        m_offer = 0;
      end
    end else begin
      m_pick(request_i & ch_enable_i & ~m_busy, ch_priority_i, m_rr, f, c, p);
      if (f) begin
        m_offer = 1; m_ch = c; m_prio = p;
      end
    end
    m_busy = nb;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    checks++; if (arb_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", arb_valid_o); end
    checks++; if (arb_channel_o !== 2'd0) begin failures++; $display("FAIL reset_channel got=%0d exp=0", arb_channel_o); end
    checks++; if (arb_priority_o !== 2'd0) begin failures++; $display("FAIL reset_priority got=%0d exp=0", arb_priority_o); end
    checks++; if (busy_o !== 4'b0000) begin failures++; $display("FAIL reset_busy got=%b exp=0000", busy_o); end
    checks++; if (done_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", done_err_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_single_request();
    apply_reset();
    ch_enable_i = 4'hF;
    request_i   = 4'b0100;
    tick();
    checks++; if (arb_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", arb_valid_o); end
    checks++; if (arb_channel_o !== 2'd2) begin failures++; $display("FAIL single_channel got=%0d exp=2", arb_channel_o); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (arb_valid_o !== 1'b1 || arb_channel_o !== 2'd2) begin
        failures++; $display("FAIL single_hold got=%0b/%0d exp=1/2", arb_valid_o, arb_channel_o);
      end
    end
    arb_ready_i = 1'b1;
    tick();
    arb_ready_i = 1'b0;
    checks++; if (arb_valid_o !== 1'b0) begin failures++; $display("FAIL single_accept_valid got=%0b exp=0", arb_valid_o); end
    checks++; if (busy_o !== 4'b0100) begin failures++; $display("FAIL single_busy got=%b exp=0100", busy_o); end
    // rr_ptr now 3: with 0,1,3 requesting at equal priority, channel 3 comes next.
    request_i = 4'b1011;
    tick();
    checks++; if (arb_valid_o !== 1'b1 || arb_channel_o !== 2'd3) begin
      failures++; $display("FAIL single_rr_ptr got=%0b/%0d exp=1/3", arb_valid_o, arb_channel_o);
    end
    $display("single_request: offered ch=%0d busy=%b", arb_channel_o, busy_o);
  endtask

  task automatic test_round_robin();
    int done_at [N];
    int expect_ch;
    int offers;
    apply_reset();
    for (int c = 0; c < N; c++) done_at[c] = -1;
    ch_enable_i = 4'hF;
    request_i   = 4'hF;
    arb_ready_i = 1'b1;
    expect_ch = 0;
    offers = 0;
    for (int t = 0; t < 40; t++) begin
      done_valid_i = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (done_at[c] == t) begin
          done_valid_i = 1'b1; done_channel_i = 2'(c); done_at[c] = -1;
        end
      end
      tick();
      checks++; if (done_err_o !== 1'b0) begin failures++; $display("FAIL rr_no_err got=%0b exp=0", done_err_o); end
      if (arb_valid_o === 1'b1) begin
        $display("round_robin: grant ch=%0d", arb_channel_o);
        checks++; if (int'(arb_channel_o) != expect_ch) begin
          failures++; $display("FAIL rr_order got=%0d exp=%0d", arb_channel_o, expect_ch);
        end
        checks++; if (busy_o[arb_channel_o] !== 1'b0) begin
          failures++; $display("FAIL rr_offer_busy got=%b exp=bit%0d clear", busy_o, arb_channel_o);
        end
        done_at[arb_channel_o] = t + 6;
        expect_ch = (expect_ch + 1) % N;
        offers++;
      end
    end
    done_valid_i = 1'b0;
    arb_ready_i  = 1'b0;
    checks++; if (offers < 8) begin failures++; $display("FAIL rr_offer_count got=%0d exp>=8", offers); end
  endtask

  task automatic test_priority();
    apply_reset();
    ch_enable_i   = 4'hF;
    ch_priority_i = {2'd3, 2'd0, 2'd1, 2'd0};
    request_i     = 4'b1010;
    tick();
    checks++; if (arb_valid_o !== 1'b1 || arb_channel_o !== 2'd3 || arb_priority_o !== 2'd3) begin
      failures++; $display("FAIL prio_first got=%0b/%0d/%0d exp=1/3/3", arb_valid_o, arb_channel_o, arb_priority_o);
    end
    arb_ready_i = 1'b1;
    tick();
    checks++; if (busy_o !== 4'b1000 || arb_valid_o !== 1'b0) begin
      failures++; $display("FAIL prio_accept got=%b/%0b exp=1000/0", busy_o, arb_valid_o);
    end
    tick();
    checks++; if (arb_valid_o !== 1'b1 || arb_channel_o !== 2'd1 || arb_priority_o !== 2'd1) begin
      failures++; $display("FAIL prio_second got=%0b/%0d/%0d exp=1/1/1", arb_valid_o, arb_channel_o, arb_priority_o);
    end
    tick();
    arb_ready_i = 1'b0;
    checks++; if (busy_o !== 4'b1010) begin failures++; $display("FAIL prio_busy got=%b exp=1010", busy_o); end
    $display("priority: busy=%b", busy_o);
  endtask

  task automatic test_masking_stability();
    apply_reset();
    ch_enable_i = 4'b1110;
    request_i   = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (arb_valid_o !== 1'b0) begin failures++; $display("FAIL mask_no_offer got=%0b exp=0", arb_valid_o); end
    end
    request_i = 4'b0011;
    tick();
    checks++; if (arb_valid_o !== 1'b1 || arb_channel_o !== 2'd1) begin
      failures++; $display("FAIL mask_offer got=%0b/%0d exp=1/1", arb_valid_o, arb_channel_o);
    end
    request_i     = 4'b0000;
    ch_enable_i   = 4'b0000;
    ch_priority_i = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (arb_valid_o !== 1'b1 || arb_channel_o !== 2'd1 || arb_priority_o !== 2'd0) begin
        failures++; $display("FAIL stable_hold got=%0b/%0d/%0d exp=1/1/0", arb_valid_o, arb_channel_o, arb_priority_o);
      end
    end
    arb_ready_i = 1'b1;
    tick();
    arb_ready_i = 1'b0;
    checks++; if (arb_valid_o !== 1'b0 || busy_o !== 4'b0010) begin
      failures++; $display("FAIL stable_accept got=%0b/%b exp=0/0010", arb_valid_o, busy_o);
    end
  endtask

  task automatic test_done_error();
    apply_reset();
    ch_enable_i    = 4'hF;
    done_valid_i   = 1'b1;
    done_channel_i = 2'd2;
    tick();
    done_valid_i = 1'b0;
    checks++; if (done_err_o !== 1'b1) begin failures++; $display("FAIL err_pulse got=%0b exp=1", done_err_o); end
    checks++; if (busy_o !== 4'b0000) begin failures++; $display("FAIL err_busy got=%b exp=0000", busy_o); end
    tick();
    checks++; if (done_err_o !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%0b exp=0", done_err_o); end
    // Make ch0 busy, then offer ch2 and accept it in the same cycle ch0 reports done.
    request_i = 4'b0001;
    tick();
    arb_ready_i = 1'b1;
    tick();
    arb_ready_i = 1'b0;
    request_i = 4'b0100;
    tick();
    checks++; if (arb_valid_o !== 1'b1 || arb_channel_o !== 2'd2 || busy_o !== 4'b0001) begin
      failures++; $display("FAIL coinc_setup got=%0b/%0d/%b exp=1/2/0001", arb_valid_o, arb_channel_o, busy_o);
    end
    arb_ready_i    = 1'b1;
    done_valid_i   = 1'b1;
    done_channel_i = 2'd0;
    request_i      = 4'b0000;
    tick();
    arb_ready_i  = 1'b0;
    done_valid_i = 1'b0;
    checks++; if (busy_o !== 4'b0100 || done_err_o !== 1'b0) begin
      failures++; $display("FAIL coinc_busy got=%b/%0b exp=0100/0", busy_o, done_err_o);
    end
    $display("done_error: busy=%b", busy_o);
  endtask

  task automatic test_reset_mid_offer();
    apply_reset();
    ch_enable_i = 4'hF;
    request_i   = 4'b0011;
    arb_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    arb_ready_i = 1'b0;
    request_i   = 4'b0100;
    tick();
    checks++; if (arb_valid_o !== 1'b1 || busy_o !== 4'b0011) begin
      failures++; $display("FAIL rst_setup got=%0b/%b exp=1/0011", arb_valid_o, busy_o);
    end
    rst_i = 1'b1;
    #1;
    checks++; if (arb_valid_o !== 1'b0 || arb_channel_o !== 2'd0 || arb_priority_o !== 2'd0) begin
      failures++; $display("FAIL rst_async_offer got=%0b/%0d/%0d exp=0/0/0", arb_valid_o, arb_channel_o, arb_priority_o);
    end
    checks++; if (busy_o !== 4'b0000 || done_err_o !== 1'b0) begin
      failures++; $display("FAIL rst_async_busy got=%b/%0b exp=0000/0", busy_o, done_err_o);
    end
    tick();
    rst_i = 1'b0;
    request_i = 4'hF;
    tick();
    checks++; if (arb_valid_o !== 1'b1 || arb_channel_o !== 2'd0) begin
      failures++; $display("FAIL rst_rr_restart got=%0b/%0d exp=1/0", arb_valid_o, arb_channel_o);
    end
  endtask

  task automatic test_random();
    apply_reset();
    m_reset();
    ch_priority_i = 8'($urandom);
    for (int t = 0; t < 500; t++) begin
      request_i   = 4'($urandom);
      ch_enable_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 7) == 0) ch_priority_i = 8'($urandom);
      arb_ready_i    = ($urandom_range(0, 2) != 0);
      done_valid_i   = ($urandom_range(0, 2) == 0);
      done_channel_i = 2'($urandom_range(0, 3));
      m_step();
      tick();
      checks++; if (arb_valid_o !== m_offer) begin
        failures++; $display("FAIL rand_valid t=%0d got=%0b exp=%0b", t, arb_valid_o, m_offer);
      end
      if (m_offer) begin
        checks++; if (int'(arb_channel_o) != m_ch || int'(arb_priority_o) != m_prio) begin
          failures++; $display("FAIL rand_offer t=%0d got=%0d/%0d exp=%0d/%0d", t, arb_channel_o, arb_priority_o, m_ch, m_prio);
        end
      end
      checks++; if (busy_o !== m_busy) begin
        failures++; $display("FAIL rand_busy t=%0d got=%b exp=%b", t, busy_o, m_busy);
      end
      checks++; if (done_err_o !== m_err) begin
        failures++; $display("FAIL rand_err t=%0d got=%0b exp=%0b", t, done_err_o, m_err);
      end
    end
    arb_ready_i  = 1'b0;
    done_valid_i = 1'b0;
    $display("random: final busy=%b", busy_o);
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_priority();
    test_masking_stability();
    test_done_error();
    test_reset_mid_offer();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
